// File: rtl/sqrt_pkg.sv
`default_nettype none
// ============================================================================
// sqrt_pkg : shared state encoding and width helpers for sqrt_iter_n | rev 1.0
// ============================================================================
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic int half_of(input int n);
        return n / 2;
    endfunction

    function automatic int remw_of(input int n);
        return n / 2 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt_step.sv
`default_nettype none
// ============================================================================
// sqrt_step : one combinational digit-by-digit square-root iteration | rev 1.0
// ============================================================================
module sqrt_step #(
    parameter int HALF = 4
) (
    input  logic [HALF-1:0] rem_in,
    input  logic [HALF-2:0] root_in,
    input  logic [1:0]      digit,
    output logic [HALF+1:0] rem_out,
    output logic [HALF-1:0] root_out
);

    // Before the last bit the partial remainder fits HALF bits and the partial
    // root fits HALF-1 bits, so only those slices are needed here.
    logic [HALF+1:0] r2;
    logic [HALF+1:0] trial;
    logic            take;

    assign r2       = {rem_in, digit};
    assign trial    = {1'b0, root_in, 2'b01};
    assign take     = (r2 >= trial);
    assign rem_out  = take ? (r2 - trial) : r2;
    assign root_out = {root_in, take};

endmodule
`default_nettype wire

// File: rtl/sqrt_iter_n.sv
`default_nettype none
// ============================================================================
// sqrt_iter_n : iterative bit-serial integer square root, go/done handshake | rev 1.0
// ============================================================================
module sqrt_iter_n
    import sqrt_pkg::*;
#(
    parameter int N     = 8,
    parameter int ROUND = 0
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  go,
    input  logic [N-1:0]          x,
    output logic                  busy,
    output logic                  done,
    output logic [half_of(N)-1:0] root,
    output logic [remw_of(N)-1:0] rem,
    output logic                  exact
);

    localparam int HALF = half_of(N);
    localparam int REMW = remw_of(N);
    localparam int ACCW = HALF + 2;
    localparam int CNTW = $clog2(HALF);

    state_t            state, state_nx;
    logic [N-1:0]      x_sh, x_sh_nx;
    logic [CNTW-1:0]   cnt, cnt_nx;
    logic [HALF-1:0]   root_acc, root_acc_nx;
    logic [ACCW-1:0]   rem_acc, rem_acc_nx;
    logic [HALF-1:0]   root_nx;
    logic [REMW-1:0]   rem_nx;
    logic              exact_nx;
    logic              done_nx;

    logic [ACCW-1:0]   step_rem;
    logic [HALF-1:0]   step_root;
    logic [HALF-1:0]   root_fin;

    sqrt_step #(
        .HALF (HALF)
    ) u_step (
        .rem_in   (rem_acc[HALF-1:0]),
        .root_in  (root_acc[HALF-2:0]),
        .digit    (x_sh[N-1:N-2]),
        .rem_out  (step_rem),
        .root_out (step_root)
    );

    // Rounding up is exact-halfway safe: x >= (r+1/2)^2 reduces to rem > r.
    generate
        if (ROUND != 0) begin : g_round
            assign root_fin = ((rem_acc > ACCW'(root_acc)) && !(&root_acc))
                            ? root_acc + {{(HALF-1){1'b0}}, 1'b1}
                            : root_acc;
        end else begin : g_floor
            assign root_fin = root_acc;
        end
    endgenerate

    assign busy = (state == CALC);

    always_comb begin
        state_nx    = state;
        x_sh_nx     = x_sh;
        cnt_nx      = cnt;
        root_acc_nx = root_acc;
        rem_acc_nx  = rem_acc;
        root_nx     = root;
        rem_nx      = rem;
        exact_nx    = exact;
        done_nx     = done;
        case (state)
            IDLE, FIN: begin
                if (go) begin
                    x_sh_nx     = x;
                    root_acc_nx = '0;
                    rem_acc_nx  = '0;
                    cnt_nx      = CNTW'(HALF - 1);
                    done_nx     = 1'b0;
                    state_nx    = CALC;
                end else if ((state == FIN) && !done) begin
                    // First FIN edge publishes the finished accumulators.
                    root_nx  = root_fin;
                    rem_nx   = rem_acc[HALF:0];
                    exact_nx = (rem_acc == '0);
                    done_nx  = 1'b1;
                end
            end
            CALC: begin
                rem_acc_nx  = step_rem;
                root_acc_nx = step_root;
                x_sh_nx     = {x_sh[N-3:0], 2'b00};
                cnt_nx      = cnt - CNTW'(1);
                if (cnt == '0) begin
                    state_nx = FIN;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            x_sh     <= '0;
            cnt      <= '0;
            root_acc <= '0;
            rem_acc  <= '0;
            root     <= '0;
            rem      <= '0;
            exact    <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            x_sh     <= x_sh_nx;
            cnt      <= cnt_nx;
            root_acc <= root_acc_nx;
            rem_acc  <= rem_acc_nx;
            root     <= root_nx;
            rem      <= rem_nx;
            exact    <= exact_nx;
            done     <= done_nx;
        end
    end

endmodule
`default_nettype wire

// File: doc/sqrt_iter_n.md
Name: sqrt_iter_n

Overview:
- Parametrised, iterative, bit-serial integer square root unit.
- Successor to the fixed 8-bit switch-driven sqrt engine; generalised to any even radicand width N.
- Adds a remainder output, an exact-square flag, a busy flag and an optional round-to-nearest mode.
- Sits between operand source (switches/registers) and display path (mux, binary-to-BCD, 7-seg driver); go/done handshake unchanged.

Parameters:
- N, 8, radicand width in bits; must be even, ≥ 4.
- ROUND, 0, 0 = floor root; 1 = round-to-nearest root, saturating at 2^(N/2)-1.

Ports:
- clk  input  1  system clock (25 MHz domain in the board top).
- clr  input  1  asynchronous, active-high reset.
- go  input  1  start request, sampled on rising clk when not busy.
- x  input  N  radicand, captured on the accepting edge.
- busy  output  1  high while computing.
- done  output  1  high while results are valid; held until next accepted go or clr.
- root  output  N/2  square root result.
- rem  output  N/2+1  floor remainder, x − floor_root².
- exact  output  1  high when rem == 0 (perfect square), valid with done.

Behaviour:
- Clock and reset are fixed: one clock, clk; clr is asynchronous and active-high.
- clr asserted, at any time including mid-operation: state=IDLE; busy, done, root, rem, exact all 0; internal x shift register, iteration counter and partial remainder cleared.
- States: IDLE, CALC, FIN.
- IDLE or FIN with go=1 at an edge:
  - capture x into the shift register; root_acc=0; rem_acc=0; counter=N/2−1.
  - Go to CALC. busy=1 and done=0 from that edge.
- CALC, one result bit per edge (digit-by-digit):
  - r2 = (rem_acc<<2) | top two bits of x_sh.
  - t = (root_acc<<2) | 1.
  - If r2 ≥ t: rem_acc = r2 − t and root_acc = (root_acc<<1) | 1. Otherwise: rem_acc = r2 and root_acc = root_acc<<1.
  - x_sh <<= 2; counter decrements.
  - Use rem_acc width N/2+2 internally so the compare never overflows.
- CALC with counter==0: after that bit, go to FIN.
- Entering FIN:
  - rem = rem_acc[N/2:0]; exact = (rem_acc==0).
  - root: ROUND=0 gives root_acc. ROUND=1 gives root_acc+1 if rem_acc > root_acc, else root_acc; if root_acc is all-ones, it saturates at all-ones.
  - busy=0, done=1.
- Latency: done rises N/2+1 edges after the go-accepting edge (N/2 CALC edges plus the FIN edge). For N=8 this is 5 clocks.
- go while busy is ignored; no queuing.
- go held high in FIN restarts every edge; done pulses low for the whole recomputation.
- Outputs root, rem and exact are registered and stable throughout FIN. During CALC they keep the previous result, but are only meaningful when done=1.
- Remainder stays the floor remainder even when ROUND=1 increments the root.

Decomposition:
- Package sqrt_pkg: state enum typedef (IDLE, CALC, FIN) and the width helper functions HALF=N/2 and REMW=N/2+1.
- One natural sub-module, sqrt_step: combinational single-iteration stage taking rem_acc, root_acc and the 2-bit digit, returning next rem_acc and root_acc.
- FSM, counter and output registers stay in sqrt_iter_n.

Test Plan:
- N=8, ROUND=0, x=144, go 1 cycle → done after 5 clocks; root=12, rem=0, exact=1. busy high exactly 4 edges.
- N=8, ROUND=0, x=200 → root=14, rem=4, exact=0. Then x=0 → root=0, rem=0, exact=1.
- N=8, ROUND=1, three cases:
  - x=210 → root=14, rem=14 (rem not > root).
  - x=211 → root=15, rem=15.
  - x=255 → floor root 15, rem=30; root saturates at 15.
- N=16, ROUND=0, x=65535 → root=255, rem=510 after 9 clocks. Also x=65025 → root=255, exact=1.
- N=8: go with x=100, then assert go with x=9 during CALC → ignored; result root=10. Then go in FIN with x=9 → done drops, returns with root=3.
- N=8: clr asserted asynchronously mid-CALC (between edges) → all outputs 0 immediately. Later go with x=49 → root=7, normal 5-clock latency.
